// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: times each high pulse, assembles 24-bit GRB pixels
// and reports frame ends on the latch gap, with glitch/stuck-high/partial-pixel errors.
module ws2812_rx #(
  parameter int MIN_HIGH     = 4,
  parameter int BIT_THRESH   = 16,
  parameter int MAX_HIGH     = 54,
  parameter int RESET_CYCLES = 1350,
  parameter int INDEX_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic [23:0]        pixel_data,
  output logic               pixel_valid,
  output logic [INDEX_W-1:0] pixel_index,
  output logic               frame_done,
  output logic [INDEX_W:0]   frame_pixels,
  output logic               error
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         sync_reg;
  logic               s_prev_reg;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [23:0]        shift_reg, shift_next;
  logic [4:0]         bit_cnt_reg, bit_cnt_next;
  logic [INDEX_W:0]   pix_cnt_reg, pix_cnt_next;
  logic [23:0]        pixel_data_reg, pixel_data_next;
  logic [INDEX_W-1:0] pixel_index_reg, pixel_index_next;
  logic [INDEX_W:0]   frame_pixels_reg, frame_pixels_next;
  logic               pixel_valid_reg, pixel_valid_next;
  logic               frame_done_reg, frame_done_next;
  logic               error_reg, error_next;

  logic s, rise, fall, bit_val;
  logic [23:0] shifted;

  // sync_reg[1] is the synchronised line; s_prev_reg lags it by one cycle for edge detection
  assign s       = sync_reg[1];
  assign rise    = s & ~s_prev_reg;
  assign fall    = ~s & s_prev_reg;
  assign bit_val = (cnt_reg >= THRESH_C);
  assign shifted = {shift_reg[22:0], bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= SYNC;
      sync_reg         <= '0;
      s_prev_reg       <= 1'b0;
      cnt_reg          <= '0;
      shift_reg        <= '0;
      bit_cnt_reg      <= '0;
      pix_cnt_reg      <= '0;
      pixel_data_reg   <= '0;
      pixel_index_reg  <= '0;
      frame_pixels_reg <= '0;
      pixel_valid_reg  <= 1'b0;
      frame_done_reg   <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sync_reg         <= {sync_reg[0], din};
      s_prev_reg       <= s;
      cnt_reg          <= cnt_next;
      shift_reg        <= shift_next;
      bit_cnt_reg      <= bit_cnt_next;
      pix_cnt_reg      <= pix_cnt_next;
      pixel_data_reg   <= pixel_data_next;
      pixel_index_reg  <= pixel_index_next;
      frame_pixels_reg <= frame_pixels_next;
      pixel_valid_reg  <= pixel_valid_next;
      frame_done_reg   <= frame_done_next;
      error_reg        <= error_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    shift_next        = shift_reg;
    bit_cnt_next      = bit_cnt_reg;
    pix_cnt_next      = pix_cnt_reg;
    pixel_data_next   = pixel_data_reg;
    pixel_index_next  = pixel_index_reg;
    frame_pixels_next = frame_pixels_reg;
    pixel_valid_next  = 1'b0;
    frame_done_next   = 1'b0;
    error_next        = 1'b0;
    cnt_next          = cnt_reg;

    if (rise || fall)
      cnt_next = CNT_W'(1);
    else if (cnt_reg != '1)
      cnt_next = cnt_reg + 1'b1;

    case (state_reg)
      SYNC: begin
        // only a full latch gap proves we are between frames
        if (!s && !fall && cnt_reg >= RESET_C)
          state_next = IDLE;
      end
      IDLE: begin
        if (rise)
          state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (cnt_reg < MIN_C) begin
            error_next   = 1'b1;
            shift_next   = '0;
            bit_cnt_next = '0;
            pix_cnt_next = '0;
            state_next   = SYNC;
          end else begin
            shift_next = shifted;
            state_next = LOW;
            if (bit_cnt_reg == 5'd23) begin
              pixel_data_next  = shifted;
              pixel_index_next = pix_cnt_reg[INDEX_W-1:0];
              pixel_valid_next = 1'b1;
              bit_cnt_next     = '0;
              if (pix_cnt_reg != '1)
                pix_cnt_next = pix_cnt_reg + 1'b1;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end else if (cnt_reg >= MAX_C) begin
          error_next   = 1'b1;
          shift_next   = '0;
          bit_cnt_next = '0;
          pix_cnt_next = '0;
          state_next   = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_next = HIGH;
        end else if (cnt_reg >= RESET_C) begin
          frame_done_next   = 1'b1;
          frame_pixels_next = pix_cnt_reg;
          error_next        = (bit_cnt_reg != '0);
          bit_cnt_next      = '0;
          pix_cnt_next      = '0;
          state_next        = IDLE;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  assign pixel_data   = pixel_data_reg;
  assign pixel_valid  = pixel_valid_reg;
  assign pixel_index  = pixel_index_reg;
  assign frame_done   = frame_done_reg;
  assign frame_pixels = frame_pixels_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives randomized pulse trains and checks pixel, frame and
// error strobes (values and cycle timing) against expectations built from the bits sent.
module tb_ws2812_rx;

  localparam int MIN_HIGH     = 4;
  localparam int BIT_THRESH   = 16;
  localparam int MAX_HIGH     = 54;
  localparam int RESET_CYCLES = 1350;
  localparam int INDEX_W      = 8;
  localparam int LAT          = 3;
  localparam int GAP          = RESET_CYCLES + 50;

  logic               clk = 1'b0;
  logic               reset;
  logic               din;
  logic [23:0]        pixel_data;
  logic               pixel_valid;
  logic [INDEX_W-1:0] pixel_index;
  logic               frame_done;
  logic [INDEX_W:0]   frame_pixels;
  logic               error;

  ws2812_rx #(
    .MIN_HIGH(MIN_HIGH), .BIT_THRESH(BIT_THRESH), .MAX_HIGH(MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES), .INDEX_W(INDEX_W)
  ) dut (
    .clk(clk), .reset(reset), .din(din),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0]        data;
    logic [INDEX_W-1:0] index;
    int                 cyc;
  } pix_t;

  pix_t pv_q[$];
  int   fd_pix_q[$];
  int   fd_cyc_q[$];
  int   er_q[$];
  pix_t pv_rec;
  int   n_cmp = 0;
  int   n_bad = 0;

  // observed strobes, one line printed per transaction
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) begin
        pv_rec.data  = pixel_data;
        pv_rec.index = pixel_index;
        pv_rec.cyc   = cyc;
        pv_q.push_back(pv_rec);
        $display("pixel  cyc=%0d index=%0d data=%06h", cyc, pixel_index, pixel_data);
      end
      if (frame_done) begin
        fd_pix_q.push_back(int'(frame_pixels));
        fd_cyc_q.push_back(cyc);
        $display("frame  cyc=%0d pixels=%0d", cyc, frame_pixels);
      end
      if (error) begin
        er_q.push_back(cyc);
        $display("error  cyc=%0d", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    tick(n);
  endtask

  task automatic clear_q();
    pv_q.delete();
    fd_pix_q.delete();
    fd_cyc_q.delete();
    er_q.delete();
  endtask

  // mode 0: random width within the bit's class; 1: boundary widths 15/16;
  // 2: fully random width, bit derived from the threshold rule; 3: fastest legal
  // pulses; 4: nominal 22/12 and 11/23 timing
  task automatic send_bits(input int n, input int mode, input logic [23:0] word_in,
                           output logic [23:0] word_out, output int last_fall);
    int   w;
    int   lo;
    logic b;
    word_out  = '0;
    last_fall = 0;
    for (int i = 0; i < n; i++) begin
      b = word_in[23-i];
      case (mode)
        0: w = b ? int'($urandom_range(MAX_HIGH-1, BIT_THRESH))
                 : int'($urandom_range(BIT_THRESH-1, MIN_HIGH));
        1: w = b ? BIT_THRESH : BIT_THRESH-1;
        2: begin
          w = int'($urandom_range(MAX_HIGH-1, MIN_HIGH));
          b = (w >= BIT_THRESH);
        end
        3: w = b ? BIT_THRESH : MIN_HIGH;
        default: w = b ? 22 : 11;
      endcase
      if (mode == 3)      lo = 2;
      else if (mode == 4) lo = b ? 12 : 23;
      else                lo = int'($urandom_range(40, 3));
      word_out = {word_out[22:0], b};
      din = 1'b1;
      tick(w);
      din = 1'b0;
      last_fall = cyc;
      tick(lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    din   = 1'b0;
    tick(5);
    n_cmp++; if (pixel_data !== 24'h0)   begin n_bad++; $display("FAIL reset_pixel_data got=%h want=0", pixel_data); end
    n_cmp++; if (pixel_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_pixel_valid got=%b want=0", pixel_valid); end
    n_cmp++; if (pixel_index !== '0)     begin n_bad++; $display("FAIL reset_pixel_index got=%0d want=0", pixel_index); end
    n_cmp++; if (frame_done !== 1'b0)    begin n_bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    n_cmp++; if (frame_pixels !== '0)    begin n_bad++; $display("FAIL reset_frame_pixels got=%0d want=0", frame_pixels); end
    n_cmp++; if (error !== 1'b0)         begin n_bad++; $display("FAIL reset_error got=%b want=0", error); end
    reset = 1'b0;
    clear_q();
    idle(RESET_CYCLES + 5);
  endtask

  task automatic test_single;
    logic [23:0] w;
    int lf;
    clear_q();
    send_bits(24, 4, 24'h5AC30F, w, lf);
    idle(GAP);
    n_cmp++; if (pv_q.size() !== 1) begin n_bad++; $display("FAIL single_pixel_count got=%0d want=1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      n_cmp++; if (pv_q[0].data !== 24'h5AC30F) begin n_bad++; $display("FAIL single_data got=%06h want=5ac30f", pv_q[0].data); end
      n_cmp++; if (pv_q[0].index !== '0) begin n_bad++; $display("FAIL single_index got=%0d want=0", pv_q[0].index); end
      n_cmp++; if (pv_q[0].cyc !== lf + LAT) begin n_bad++; $display("FAIL single_latency got=%0d want=%0d", pv_q[0].cyc, lf + LAT); end
    end
    n_cmp++; if (fd_pix_q.size() !== 1) begin n_bad++; $display("FAIL single_frame_count got=%0d want=1", fd_pix_q.size()); end
    if (fd_pix_q.size() > 0) begin
      n_cmp++; if (fd_pix_q[0] !== 1) begin n_bad++; $display("FAIL single_frame_pixels got=%0d want=1", fd_pix_q[0]); end
      n_cmp++; if (fd_cyc_q[0] !== lf + RESET_CYCLES + LAT) begin n_bad++; $display("FAIL single_frame_latency got=%0d want=%0d", fd_cyc_q[0], lf + RESET_CYCLES + LAT); end
    end
    n_cmp++; if (er_q.size() !== 0) begin n_bad++; $display("FAIL single_error_count got=%0d want=0", er_q.size()); end
    n_cmp++; if (pixel_data !== 24'h5AC30F) begin n_bad++; $display("FAIL single_data_hold got=%06h want=5ac30f", pixel_data); end
  endtask

  task automatic test_multi(input int mode, input int npix, input string name);
    logic [23:0] sent[$];
    int          falls[$];
    logic [23:0] w;
    logic [31:0] r;
    int          lf;
    clear_q();
    for (int k = 0; k < npix; k++) begin
      r = $urandom();
      if (mode == 0 && npix == 3) r[23:0] = (k == 0) ? 24'hFFFFFF : (k == 1) ? 24'h000000 : 24'h800001;
      send_bits(24, mode, r[23:0], w, lf);
      sent.push_back(w);
      falls.push_back(lf);
    end
    idle(GAP);
    n_cmp++; if (pv_q.size() !== npix) begin n_bad++; $display("FAIL %s_pixel_count got=%0d want=%0d", name, pv_q.size(), npix); end
    for (int k = 0; k < npix; k++) begin
      if (k < pv_q.size()) begin
        n_cmp++; if (pv_q[k].data !== sent[k]) begin n_bad++; $display("FAIL %s_data[%0d] got=%06h want=%06h", name, k, pv_q[k].data, sent[k]); end
        n_cmp++; if (pv_q[k].index !== INDEX_W'(k)) begin n_bad++; $display("FAIL %s_index[%0d] got=%0d want=%0d", name, k, pv_q[k].index, k); end
        n_cmp++; if (pv_q[k].cyc !== falls[k] + LAT) begin n_bad++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, k, pv_q[k].cyc, falls[k] + LAT); end
      end
    end
    n_cmp++; if (fd_pix_q.size() !== 1) begin n_bad++; $display("FAIL %s_frame_count got=%0d want=1", name, fd_pix_q.size()); end
    if (fd_pix_q.size() > 0) begin
      n_cmp++; if (fd_pix_q[0] !== npix) begin n_bad++; $display("FAIL %s_frame_pixels got=%0d want=%0d", name, fd_pix_q[0], npix); end
      n_cmp++; if (fd_cyc_q[0] !== falls[npix-1] + RESET_CYCLES + LAT) begin n_bad++; $display("FAIL %s_frame_latency got=%0d want=%0d", name, fd_cyc_q[0], falls[npix-1] + RESET_CYCLES + LAT); end
    end
    n_cmp++; if (er_q.size() !== 0) begin n_bad++; $display("FAIL %s_error_count got=%0d want=0", name, er_q.size()); end
  endtask

  task automatic test_glitch;
    logic [23:0] w;
    logic [31:0] r;
    int lf, gf;
    clear_q();
    r = $urandom();
    send_bits(10, 0, r[23:0], w, lf);
    din = 1'b1;
    tick(MIN_HIGH - 1);
    din = 1'b0;
    gf = cyc;
    tick(20);
    r = $urandom();
    send_bits(24, 0, r[23:0], w, lf);
    idle(GAP);
    r = $urandom();
    send_bits(24, 0, r[23:0], w, lf);
    idle(GAP);
    n_cmp++; if (er_q.size() !== 1) begin n_bad++; $display("FAIL glitch_error_count got=%0d want=1", er_q.size()); end
    if (er_q.size() > 0) begin
      n_cmp++; if (er_q[0] !== gf + LAT) begin n_bad++; $display("FAIL glitch_error_cycle got=%0d want=%0d", er_q[0], gf + LAT); end
    end
    n_cmp++; if (pv_q.size() !== 1) begin n_bad++; $display("FAIL glitch_pixel_count got=%0d want=1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      n_cmp++; if (pv_q[0].data !== w) begin n_bad++; $display("FAIL glitch_data got=%06h want=%06h", pv_q[0].data, w); end
      n_cmp++; if (pv_q[0].index !== '0) begin n_bad++; $display("FAIL glitch_index got=%0d want=0", pv_q[0].index); end
      n_cmp++; if (pv_q[0].cyc !== lf + LAT) begin n_bad++; $display("FAIL glitch_latency got=%0d want=%0d", pv_q[0].cyc, lf + LAT); end
    end
    n_cmp++; if (fd_pix_q.size() !== 1) begin n_bad++; $display("FAIL glitch_frame_count got=%0d want=1", fd_pix_q.size()); end
  endtask

  task automatic test_partial;
    logic [23:0] w;
    logic [31:0] r;
    int lf;
    clear_q();
    r = $urandom();
    send_bits(12, 0, r[23:0], w, lf);
    idle(GAP);
    n_cmp++; if (pv_q.size() !== 0) begin n_bad++; $display("FAIL partial_pixel_count got=%0d want=0", pv_q.size()); end
    n_cmp++; if (fd_pix_q.size() !== 1) begin n_bad++; $display("FAIL partial_frame_count got=%0d want=1", fd_pix_q.size()); end
    n_cmp++; if (er_q.size() !== 1) begin n_bad++; $display("FAIL partial_error_count got=%0d want=1", er_q.size()); end
    if (fd_pix_q.size() > 0 && er_q.size() > 0) begin
      n_cmp++; if (fd_pix_q[0] !== 0) begin n_bad++; $display("FAIL partial_frame_pixels got=%0d want=0", fd_pix_q[0]); end
      n_cmp++; if (fd_cyc_q[0] !== lf + RESET_CYCLES + LAT) begin n_bad++; $display("FAIL partial_frame_cycle got=%0d want=%0d", fd_cyc_q[0], lf + RESET_CYCLES + LAT); end
      n_cmp++; if (er_q[0] !== fd_cyc_q[0]) begin n_bad++; $display("FAIL partial_error_cycle got=%0d want=%0d", er_q[0], fd_cyc_q[0]); end
    end
  endtask

  task automatic test_stuck;
    int rc;
    clear_q();
    din = 1'b1;
    rc  = cyc;
    tick(60);
    din = 1'b0;
    idle(GAP);
    n_cmp++; if (er_q.size() !== 1) begin n_bad++; $display("FAIL stuck_error_count got=%0d want=1", er_q.size()); end
    if (er_q.size() > 0) begin
      n_cmp++; if (er_q[0] !== rc + MAX_HIGH + LAT) begin n_bad++; $display("FAIL stuck_error_cycle got=%0d want=%0d", er_q[0], rc + MAX_HIGH + LAT); end
    end
    n_cmp++; if (pv_q.size() + fd_pix_q.size() !== 0) begin n_bad++; $display("FAIL stuck_other_strobes got=%0d want=0", pv_q.size() + fd_pix_q.size()); end
  endtask

  task automatic test_reset_mid;
    logic [23:0] w;
    logic [31:0] r;
    int lf;
    r = $urandom();
    send_bits(9, 0, r[23:0], w, lf);
    din = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(2);
    din = 1'b0;
    tick(3);
    n_cmp++; if (pixel_data !== 24'h0) begin n_bad++; $display("FAIL reset_mid_pixel_data got=%06h want=0", pixel_data); end
    n_cmp++; if (frame_pixels !== '0) begin n_bad++; $display("FAIL reset_mid_frame_pixels got=%0d want=0", frame_pixels); end
    reset = 1'b0;
    clear_q();
    idle(GAP);
    r = $urandom();
    send_bits(24, 0, r[23:0], w, lf);
    idle(GAP);
    n_cmp++; if (pv_q.size() !== 1) begin n_bad++; $display("FAIL reset_mid_pixel_count got=%0d want=1", pv_q.size()); end
    if (pv_q.size() > 0) begin
      n_cmp++; if (pv_q[0].data !== w) begin n_bad++; $display("FAIL reset_mid_data got=%06h want=%06h", pv_q[0].data, w); end
      n_cmp++; if (pv_q[0].index !== '0) begin n_bad++; $display("FAIL reset_mid_index got=%0d want=0", pv_q[0].index); end
    end
    n_cmp++; if (er_q.size() !== 0) begin n_bad++; $display("FAIL reset_mid_error_count got=%0d want=0", er_q.size()); end
  endtask

  task automatic test_back_to_back;
    localparam int NPIX = (1 << INDEX_W) + 1;
    logic [23:0] w;
    int lf;
    clear_q();
    for (int k = 0; k < NPIX; k++)
      send_bits(24, 3, 24'h000000, w, lf);
    idle(GAP);
    n_cmp++; if (pv_q.size() !== NPIX) begin n_bad++; $display("FAIL b2b_pixel_count got=%0d want=%0d", pv_q.size(), NPIX); end
    for (int k = 0; k < NPIX; k++) begin
      if (k < pv_q.size()) begin
        n_cmp++; if (pv_q[k].index !== INDEX_W'(k % (1 << INDEX_W))) begin n_bad++; $display("FAIL b2b_index[%0d] got=%0d want=%0d", k, pv_q[k].index, k % (1 << INDEX_W)); end
      end
    end
    n_cmp++; if (fd_pix_q.size() !== 1) begin n_bad++; $display("FAIL b2b_frame_count got=%0d want=1", fd_pix_q.size()); end
    if (fd_pix_q.size() > 0) begin
      n_cmp++; if (fd_pix_q[0] !== NPIX) begin n_bad++; $display("FAIL b2b_frame_pixels got=%0d want=%0d", fd_pix_q[0], NPIX); end
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_multi(0, 3, "multi");
    test_multi(1, 2, "threshold");
    test_multi(2, 4, "random");
    test_glitch();
    test_partial();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
